// File: rtl/mem_arb_pkg.sv
// Shared constants for the memory request arbiter: default widths,
// packet field offsets and the read/write encoding.
package mem_arb_pkg;

   localparam int NUM_REQ_DEF       = 4;
   localparam int REQ_IDX_WIDTH_DEF = 2;
   localparam int DATA_WIDTH_DEF    = 32;
   localparam int ADDR_WIDTH_DEF    = 31;
   localparam int TID_WIDTH_DEF     = 16;
   localparam int MAX_OUT_DEF       = 7;
   localparam int CNT_WIDTH_DEF     = 3;

   // Request type encoding on req_rw and in the packed request word
   localparam logic RW_READ  = 1'b1;
   localparam logic RW_WRITE = 1'b0;

   // Request word is {tid, rw, addr, data}, data in the low bits
   function automatic int dp_addr_lsb(int dw);
      return dw;
   endfunction

   function automatic int dp_rw_lsb(int dw, int aw);
      return dw + aw;
   endfunction

   function automatic int dp_tid_lsb(int dw, int aw);
      return dw + aw + 1;
   endfunction

   // Response word is {tid, data}, data in the low bits
   function automatic int vpi_tid_lsb(int dw);
      return dw;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant selection: searches upward from the requester after
// the last one granted and returns a one-hot grant.
module rr_arbiter
   import mem_arb_pkg::*;
#(
   parameter int NUM_REQ       = NUM_REQ_DEF,
   parameter int REQ_IDX_WIDTH = REQ_IDX_WIDTH_DEF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_REQ-1:0] eligible,
   input  logic               advance,
   output logic [NUM_REQ-1:0] grant
);

   logic [REQ_IDX_WIDTH-1:0] last;
   logic [REQ_IDX_WIDTH-1:0] grant_idx;
   logic                     found;
   int                       idx;

   // Pick the first eligible requester after the last grant, wrapping
   always_comb begin
      grant     = '0;
      grant_idx = last;
      found     = 1'b0;
      idx       = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = (int'(last) + 1 + k) % NUM_REQ;
         if (!found && eligible[idx]) begin
            grant[idx] = 1'b1;
            grant_idx  = REQ_IDX_WIDTH'(idx);
            found      = 1'b1;
         end
      end
   end

   // Pointer resets to the top index so requester 0 is searched first
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         last <= REQ_IDX_WIDTH'(NUM_REQ - 1);
      else if (advance)
         last <= grant_idx;
   end

endmodule

// File: rtl/mem_req_arbiter.sv
// Memory request arbiter: round-robin grants requesters into a one-entry
// output stage feeding the request FIFO, tags each request with a
// transaction ID, tracks per-requester outstanding counts and routes
// responses back by the requester index held in the low tid bits.
//
// Handshakes: a request transfers on a cycle where req_valid[i] and
// req_ready[i] are both high (req_ready is combinational, at most one bit);
// the stage pushes when dp_wr_en is high, which only happens while
// dp_full is low; responses pop whenever the FIFO is non-empty and are
// strobed on rsp_valid with no backpressure.
module mem_req_arbiter
   import mem_arb_pkg::*;
#(
   parameter int NUM_REQ       = NUM_REQ_DEF,
   parameter int REQ_IDX_WIDTH = REQ_IDX_WIDTH_DEF,
   parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
   parameter int ADDR_WIDTH    = ADDR_WIDTH_DEF,
   parameter int TID_WIDTH     = TID_WIDTH_DEF,
   parameter int MAX_OUT       = MAX_OUT_DEF,
   parameter int CNT_WIDTH     = CNT_WIDTH_DEF
) (
   input  logic                                     clk,
   input  logic                                     reset,
   input  logic [NUM_REQ-1:0]                       req_valid,
   output logic [NUM_REQ-1:0]                       req_ready,
   input  logic [NUM_REQ-1:0]                       req_rw,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]            req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]            req_data,
   output logic                                     dp_wr_en,
   output logic [TID_WIDTH+1+ADDR_WIDTH+DATA_WIDTH-1:0] dp_data_in,
   input  logic                                     dp_full,
   output logic                                     vpi_rd_en,
   input  logic [TID_WIDTH+DATA_WIDTH-1:0]          vpi_data_out,
   input  logic                                     vpi_empty,
   output logic [NUM_REQ-1:0]                       rsp_valid,
   output logic [TID_WIDTH-1:0]                     rsp_tid,
   output logic [DATA_WIDTH-1:0]                    rsp_data,
   output logic                                     err_unexpected
);

   localparam int SEQ_W       = TID_WIDTH - REQ_IDX_WIDTH;
   localparam int DP_ADDR_LSB = dp_addr_lsb(DATA_WIDTH);
   localparam int DP_RW_LSB   = dp_rw_lsb(DATA_WIDTH, ADDR_WIDTH);
   localparam int DP_TID_LSB  = dp_tid_lsb(DATA_WIDTH, ADDR_WIDTH);
   localparam int VPI_TID_LSB = vpi_tid_lsb(DATA_WIDTH);

   logic [CNT_WIDTH-1:0]     cnt [NUM_REQ];
   logic [NUM_REQ-1:0]       eligible;
   logic [NUM_REQ-1:0]       grant;
   logic [NUM_REQ-1:0]       cnt_dec;
   logic                     can_load;
   logic                     accept;
   logic [REQ_IDX_WIDTH-1:0] grant_idx;
   logic [REQ_IDX_WIDTH-1:0] rsp_idx;
   logic                     stage_valid;
   logic [TID_WIDTH-1:0]     stage_tid;
   logic                     stage_rw;
   logic [ADDR_WIDTH-1:0]    stage_addr;
   logic [DATA_WIDTH-1:0]    stage_data;
   logic [SEQ_W-1:0]         seq;
   logic                     rd_pending;

   // Stage may take a new entry when empty or draining this cycle;
   // held off while reset is active so req_ready reads zero
   assign dp_wr_en  = stage_valid & ~dp_full;
   assign can_load  = reset & (~stage_valid | dp_wr_en);
   assign vpi_rd_en = reset & ~vpi_empty;

   assign dp_data_in[DATA_WIDTH-1:0]             = stage_data;
   assign dp_data_in[DP_ADDR_LSB +: ADDR_WIDTH]  = stage_addr;
   assign dp_data_in[DP_RW_LSB]                  = stage_rw;
   assign dp_data_in[DP_TID_LSB +: TID_WIDTH]    = stage_tid;

   // Requester is eligible while valid and under its outstanding limit
   always_comb begin
      eligible = '0;
      for (int i = 0; i < NUM_REQ; i++)
         eligible[i] = req_valid[i] & (cnt[i] < CNT_WIDTH'(MAX_OUT)) & can_load;
   end

   rr_arbiter #(
      .NUM_REQ       (NUM_REQ),
      .REQ_IDX_WIDTH (REQ_IDX_WIDTH)
   ) u_rr (
      .clk      (clk),
      .reset    (reset),
      .eligible (eligible),
      .advance  (accept),
      .grant    (grant)
   );

   assign req_ready = grant;
   assign accept    = |grant;

   // Encode the one-hot grant to an index for muxing and the tid
   always_comb begin
      grant_idx = '0;
      for (int i = 0; i < NUM_REQ; i++)
         if (grant[i]) grant_idx = REQ_IDX_WIDTH'(i);
   end

   // Output stage: load on grant, clear on push, hold while full
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stage_valid <= 1'b0;
         stage_tid   <= '0;
         stage_rw    <= 1'b0;
         stage_addr  <= '0;
         stage_data  <= '0;
      end else if (accept) begin
         stage_valid <= 1'b1;
         stage_tid   <= {seq, grant_idx};
         stage_rw    <= req_rw[grant_idx];
         stage_addr  <= req_addr[int'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
         stage_data  <= req_data[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
      end else if (dp_wr_en) begin
         stage_valid <= 1'b0;
      end
   end

   // Sequence number advances once per accepted request, wrapping
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         seq <= '0;
      else if (accept)
         seq <= seq + SEQ_W'(1);
   end

   // Response data is valid the cycle after the pop
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         rd_pending <= 1'b0;
      else
         rd_pending <= vpi_rd_en;
   end

   assign rsp_idx        = vpi_data_out[VPI_TID_LSB +: REQ_IDX_WIDTH];
   assign rsp_tid        = vpi_data_out[VPI_TID_LSB +: TID_WIDTH];
   assign rsp_data       = vpi_data_out[DATA_WIDTH-1:0];
   assign rsp_valid      = rd_pending ? (NUM_REQ'(1) << rsp_idx) : '0;
   assign err_unexpected = rd_pending & (cnt[rsp_idx] == '0);

   // A response only decrements a non-zero count, so no underflow
   always_comb begin
      cnt_dec = '0;
      for (int i = 0; i < NUM_REQ; i++)
         cnt_dec[i] = rsp_valid[i] & (cnt[i] != '0);
   end

   // Outstanding counters: up on accept, down on response, both = hold
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_REQ; i++) cnt[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i] && !cnt_dec[i])
               cnt[i] <= cnt[i] + CNT_WIDTH'(1);
            else if (!grant[i] && cnt_dec[i])
               cnt[i] <= cnt[i] - CNT_WIDTH'(1);
         end
      end
   end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter with a queue-based scoreboard.
module tb_mem_req_arbiter;
   import mem_arb_pkg::*;

   localparam int N    = 4;
   localparam int DW   = 32;
   localparam int AW   = 31;
   localparam int TW   = 16;
   localparam int DPW  = TW + 1 + AW + DW;
   localparam int RSPW = 1 + N + TW + DW;

   logic            clk = 1'b0;
   logic            reset;
   logic [N-1:0]    req_valid;
   logic [N-1:0]    req_ready;
   logic [N-1:0]    req_rw;
   logic [N*AW-1:0] req_addr;
   logic [N*DW-1:0] req_data;
   logic            dp_wr_en;
   logic [DPW-1:0]  dp_data_in;
   logic            dp_full;
   logic            vpi_rd_en;
   logic [TW+DW-1:0] vpi_data_out;
   logic            vpi_empty;
   logic [N-1:0]    rsp_valid;
   logic [TW-1:0]   rsp_tid;
   logic [DW-1:0]   rsp_data;
   logic            err_unexpected;

   logic [DPW-1:0]  exp_dp_q[$];
   logic [RSPW-1:0] exp_rsp_q[$];
   int              pass_cnt  = 0;
   int              total_cnt = 0;
   logic [N-1:0]    rw_pat;

   mem_req_arbiter dut (
      .clk            (clk),
      .reset          (reset),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_rw         (req_rw),
      .req_addr       (req_addr),
      .req_data       (req_data),
      .dp_wr_en       (dp_wr_en),
      .dp_data_in     (dp_data_in),
      .dp_full        (dp_full),
      .vpi_rd_en      (vpi_rd_en),
      .vpi_data_out   (vpi_data_out),
      .vpi_empty      (vpi_empty),
      .rsp_valid      (rsp_valid),
      .rsp_tid        (rsp_tid),
      .rsp_data       (rsp_data),
      .err_unexpected (err_unexpected)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   function automatic logic [AW-1:0] addr_of(int i);
      return AW'(32'h100 * (i + 1));
   endfunction

   function automatic logic [DW-1:0] data_of(int i);
      return 32'hD000_0000 + DW'(i);
   endfunction

   function automatic logic [DPW-1:0] pkt(logic [TW-1:0] tid, int i);
      return {tid, rw_pat[i], addr_of(i), data_of(i)};
   endfunction

   task automatic check(string name, logic [127:0] act, logic [127:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic fail_now(string name, logic [127:0] act);
      total_cnt++;
      $display("FAIL %s: got %0h expected no output", name, act);
   endtask

   // scoreboard monitor: pops an expectation for every DUT output event
   always @(negedge clk) begin
      if (reset === 1'b1) begin
         if (dp_wr_en) begin
            if (exp_dp_q.size() == 0) fail_now("dp_extra_push", dp_data_in);
            else check("dp_push", dp_data_in, exp_dp_q.pop_front());
         end
         if (rsp_valid != '0 || err_unexpected) begin
            if (exp_rsp_q.size() == 0)
               fail_now("rsp_extra", {err_unexpected, rsp_valid, rsp_tid, rsp_data});
            else
               check("rsp", {err_unexpected, rsp_valid, rsp_tid, rsp_data}, exp_rsp_q.pop_front());
         end
      end
   end

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      tick();
      reset     = 1'b0;
      req_valid = '0;
      vpi_empty = 1'b1;
      dp_full   = 1'b0;
      @(negedge clk);
      check("reset_outputs", {req_ready, dp_wr_en, vpi_rd_en, rsp_valid, err_unexpected}, '0);
      tick();
      tick();
      reset = 1'b1;
   endtask

   // One request cycle; pushes the expected packet when a grant is due
   task automatic cycle(logic [N-1:0] valid, logic [N-1:0] exp_ready,
                        logic [TW-1:0] exp_tid, string name);
      tick();
      req_valid = valid;
      for (int i = 0; i < N; i++)
         if (exp_ready[i]) exp_dp_q.push_back(pkt(exp_tid, i));
      @(negedge clk);
      check(name, req_ready, exp_ready);
   endtask

   task automatic idle(int n);
      for (int k = 0; k < n; k++) begin
         tick();
         req_valid = '0;
         @(negedge clk);
      end
   endtask

   task automatic send_rsp(logic [TW-1:0] tid, logic [DW-1:0] data,
                           logic [N-1:0] exp_valid, logic exp_err);
      tick();
      vpi_empty = 1'b0;
      @(negedge clk);
      check("vpi_rd_en", vpi_rd_en, 1'b1);
      tick();
      vpi_empty    = 1'b1;
      vpi_data_out = {tid, data};
      exp_rsp_q.push_back({exp_err, exp_valid, tid, data});
      @(negedge clk);
   endtask

   task automatic check_drained(string name);
      check(name, {16'(exp_dp_q.size()), 16'(exp_rsp_q.size())}, '0);
   endtask

   logic [TW-1:0] t1_tid [5];

   initial begin
      reset        = 1'b0;
      req_valid    = '0;
      dp_full      = 1'b0;
      vpi_empty    = 1'b1;
      vpi_data_out = '0;
      rw_pat       = {RW_WRITE, RW_READ, RW_WRITE, RW_READ};
      req_rw       = rw_pat;
      for (int i = 0; i < N; i++) begin
         req_addr[i*AW +: AW] = addr_of(i);
         req_data[i*DW +: DW] = data_of(i);
      end
      t1_tid = '{16'h0000, 16'h0005, 16'h000A, 16'h000F, 16'h0010};

      // all requesters valid: round-robin 0,1,2,3,0
      apply_reset();
      for (int k = 0; k < 5; k++)
         cycle(4'hF, 4'(1 << (k % 4)), t1_tid[k], "rr_grant");
      idle(2);
      check_drained("rr_drained");

      // requester 2 hits its limit, then one response frees a slot
      apply_reset();
      for (int k = 0; k < 7; k++)
         cycle(4'h4, 4'h4, TW'((k << 2) | 2), "limit_grant");
      for (int k = 0; k < 2; k++)
         cycle(4'h4, 4'h0, '0, "limit_held");
      send_rsp(16'h0002, 32'hCAFE0002, 4'b0100, 1'b0);
      check("limit_rsp_cycle_held", req_ready, 4'h0);
      cycle(4'h4, 4'h4, 16'h001E, "limit_reaccept");
      idle(2);
      check_drained("limit_drained");

      // downstream full holds the stage and blocks grants
      apply_reset();
      dp_full = 1'b1;
      cycle(4'h3, 4'h1, 16'h0000, "full_grant");
      for (int k = 0; k < 5; k++) begin
         tick();
         req_valid = 4'h2;
         @(negedge clk);
         check("full_wr_en", dp_wr_en, 1'b0);
         check("full_stage", dp_data_in, pkt(16'h0000, 0));
         check("full_no_grant", req_ready, 4'h0);
      end
      tick();
      req_valid = '0;
      dp_full   = 1'b0;
      @(negedge clk);
      check("release_push", dp_wr_en, 1'b1);
      tick();
      @(negedge clk);
      check("release_single", dp_wr_en, 1'b0);
      check_drained("full_drained");

      // response routed to requester 3
      apply_reset();
      cycle(4'h8, 4'h8, 16'h0003, "rsp3_grant");
      idle(2);
      send_rsp(16'h0013, 32'hDEADBEEF, 4'b1000, 1'b0);
      idle(1);
      check_drained("rsp3_drained");

      // unexpected response: error pulse, count stays at zero
      apply_reset();
      send_rsp(16'h0001, 32'h12345678, 4'b0010, 1'b1);
      for (int k = 0; k < 7; k++)
         cycle(4'h2, 4'h2, TW'((k << 2) | 1), "err_count_zero");
      cycle(4'h2, 4'h0, '0, "err_limit");
      idle(2);
      check_drained("err_drained");

      // reset mid-traffic drops stage entry and pending response
      apply_reset();
      cycle(4'hF, 4'h1, 16'h0000, "midrst_pre0");
      cycle(4'hF, 4'h2, 16'h0005, "midrst_pre1");
      tick();
      req_valid    = 4'hF;
      vpi_empty    = 1'b0;
      vpi_data_out = {16'h0001, 32'h11111111};
      @(negedge clk);
      check("midrst_pre2", req_ready, 4'h4);
      check("midrst_pop", vpi_rd_en, 1'b1);
      tick();
      reset = 1'b0;
      #1;
      check("midrst_outputs", {req_ready, dp_wr_en, vpi_rd_en, rsp_valid, err_unexpected}, '0);
      check_drained("midrst_queue");
      tick();
      tick();
      reset     = 1'b1;
      vpi_empty = 1'b1;
      req_valid = '0;
      cycle(4'hF, 4'h1, 16'h0000, "midrst_post0");
      cycle(4'hF, 4'h2, 16'h0005, "midrst_post1");
      idle(2);
      check_drained("midrst_drained");

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/mem_req_arbiter.md
MEM_REQ_ARBITER -- requirements
Module: mem_req_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, meaning the number of requester ports.
REQ-002 SHALL have parameter REQ_IDX_WIDTH, default 2, meaning log2(NUM_REQ).
REQ-003 SHALL have parameters DATA_WIDTH, ADDR_WIDTH and TID_WIDTH, defaults 32, 31 and 16, meaning the data, address and transaction-ID widths.
REQ-004 SHALL have parameter MAX_OUT, default 7, meaning the per-requester outstanding-request limit (MAX_OUT < 2**CNT_WIDTH).
REQ-005 SHALL have parameter CNT_WIDTH, default 3, meaning the outstanding-counter width.
REQ-006 SHALL have clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-007 SHALL have reset, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have req_valid, input, NUM_REQ bits: per-requester request valid.
REQ-009 SHALL have req_ready, output, NUM_REQ bits: per-requester accept strobe, one-hot or zero.
REQ-010 SHALL have req_rw, input, NUM_REQ bits: request type, 1 = read, 0 = write.
REQ-011 SHALL have req_addr, input, NUM_REQ*ADDR_WIDTH bits: packed addresses; requester i at slice i.
REQ-012 SHALL have req_data, input, NUM_REQ*DATA_WIDTH bits: packed write data.
REQ-013 SHALL have dp_wr_en, output, 1 bit: push strobe into the downstream request FIFO.
REQ-014 SHALL have dp_data_in, output, TID_WIDTH+1+ADDR_WIDTH+DATA_WIDTH bits, packed as {tid, rw, addr, data}.
REQ-015 SHALL have dp_full, input, 1 bit: request FIFO full.
REQ-016 SHALL have vpi_rd_en, output, 1 bit: pop strobe into the response FIFO.
REQ-017 SHALL have vpi_data_out, input, TID_WIDTH+DATA_WIDTH bits, packed as {tid, data}; valid the cycle after vpi_rd_en.
REQ-018 SHALL have vpi_empty, input, 1 bit: response FIFO empty.
REQ-019 SHALL have rsp_valid, output, NUM_REQ bits: one-cycle response strobe, one-hot or zero.
REQ-020 SHALL have rsp_tid, output, TID_WIDTH bits, and rsp_data, output, DATA_WIDTH bits: the response payload.
REQ-021 SHALL have err_unexpected, output, 1 bit: one-cycle pulse when a response arrives for a requester with zero outstanding requests.

Function
REQ-022 SHALL treat requester i as eligible when req_valid[i]=1 and its outstanding count < MAX_OUT.
REQ-023 SHALL grant at most one eligible requester per cycle, round-robin, searching upward from (last grant + 1) mod NUM_REQ.
REQ-024 SHALL grant only when the output stage is empty, or when it drains this cycle (dp_wr_en=1).
REQ-025 SHALL assert req_ready[g] combinationally in the grant cycle, so acceptance = req_valid & req_ready.
REQ-026 SHALL, on grant, load the output stage with {seq, g, rw, addr, data}; tid = {seq[TID_WIDTH-REQ_IDX_WIDTH-1:0], g}.
REQ-027 SHALL increment seq by 1 per accepted request, wrapping modulo 2**(TID_WIDTH-REQ_IDX_WIDTH).
REQ-028 SHALL assert dp_wr_en = stage_valid & !dp_full, giving 1-cycle latency from acceptance to push when not full.
REQ-029 SHALL hold the stage contents unchanged while dp_full=1 (no loss, no duplication).
REQ-030 SHALL assert vpi_rd_en = !vpi_empty & !reset-active.
REQ-031 SHALL, the cycle after vpi_rd_en, drive rsp_valid[tid[REQ_IDX_WIDTH-1:0]]=1 with rsp_tid/rsp_data taken from vpi_data_out.
REQ-032 SHALL provide no backpressure on responses; requesters accept every rsp_valid strobe.
REQ-033 SHALL increment a requester's count on acceptance and decrement it on rsp_valid; when both occur in one cycle, the count is unchanged.
REQ-034 SHALL, on a response to a requester with count 0, pulse err_unexpected, still strobe rsp_valid, and leave the count at 0 (no underflow).
REQ-035 SHALL leave rsp_tid/rsp_data unspecified when rsp_valid=0 (holding the last value is permitted).

Reset
REQ-036 SHALL, on reset=0, asynchronously clear the stage valid flag, seq, all counts, rd_pending, rsp_valid, err_unexpected, dp_wr_en, vpi_rd_en and req_ready, and set the round-robin pointer so requester 0 has highest priority.
REQ-037 SHALL discard any in-flight stage entry or pending response on reset mid-operation.

Structure
REQ-038 SHALL take the width constants, packet field offsets and the rw encoding from shared package mem_arb_pkg.
REQ-039 SHALL implement grant selection in sub-module rr_arbiter (inputs: eligible vector, advance; output: one-hot grant; internal pointer).

Verification
REQ-040 SHALL verify: req_valid=4'b1111 continuously, dp_full=0 -> grants 0,1,2,3,0…; tids 0x0000, 0x0005, 0x000A, 0x000F.
REQ-041 SHALL verify: requester 2 issues 7 reads with no responses -> 8th held with req_ready[2]=0; one response with tid low bits=2 -> accepted the next cycle.
REQ-042 SHALL verify: dp_full=1 for 5 cycles with the stage loaded -> dp_wr_en=0, dp_data_in stable, no new grant; on release -> exactly one push.
REQ-043 SHALL verify: vpi_data_out={0x0013, 0xDEADBEEF} after pop -> rsp_valid=4'b1000, rsp_data=0xDEADBEEF one cycle after vpi_rd_en.
REQ-044 SHALL verify: response for requester 1 with count 0 -> err_unexpected pulse, count stays 0.
REQ-045 SHALL verify: reset=0 asserted mid-traffic -> all outputs 0 immediately; first grant after release goes to requester 0 with tid 0x0000.
